note_key_encoder: RTL and testbench

- Front end of the piano datapath: turns 8 raw key switches into the 4-bit note code consumed by the LED display and tone generator.
- Synchronizes and debounces the keys, then priority-encodes them.
- Holds a registered note output with a one-cycle change strobe.
- Note code space is shared with the display: 0=C5, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C4, 8=none.

---
 rtl/piano_pkg.sv | 32 +++
 rtl/note_key_encoder_debounce.sv | 43 ++++
 rtl/note_key_encoder.sv | 102 ++++++++++
 tb/tb_note_key_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared note-code constants and FSM state encoding for the piano datapath
// (key encoder, display decoder and tone generator all import this).
package piano_pkg;

  localparam int NOTE_W   = 4;
  localparam int NUM_KEYS = 8;

  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } state_t;

  // Lowest set bit wins so the highest-pitch key (C5) has priority.
  function automatic logic [NOTE_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] v);
    lowest_key = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_key = NOTE_W'(i);
    end
  endfunction

endpackage

// File: rtl/note_key_encoder_debounce.sv
// key_debounce: two-flop synchronizer plus whole-vector debounce; the stable
// vector only changes after the synchronized keys hold still for DEBOUNCE_CYCLES.
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] stable
);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] sync_prev;
  logic [DB_W-1:0]     cnt;

  // Any bounce (sync differing from its previous value) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync      <= '0;
      sync_prev <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync1     <= keys;
      sync      <= sync1;
      sync_prev <= sync;
      if (sync == stable || sync != sync_prev) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_key_encoder.sv
// Debounced key switches -> registered 4-bit note code with change strobe.
// Define NOTE_SUSTAIN_EN to hold the last note for SUSTAIN_CYCLES after release.
module note_key_encoder
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int SUSTAIN_CYCLES  = 25000000,
  parameter int SUS_W           = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NOTE_W-1:0]   note,
  output logic                note_change,
  output logic                multi
);

  logic [NUM_KEYS-1:0] stable;
  logic [NOTE_W-1:0]   enc;
  state_t              state;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .keys   (keys),
    .stable (stable)
  );

  assign enc = lowest_key(stable);

`ifdef NOTE_SUSTAIN_EN
  logic [SUS_W-1:0] sus_cnt;
`else
  localparam int unused_sustain_cfg = SUSTAIN_CYCLES + SUS_W;
`endif

  // note_change is raised only on cycles where note is loaded with a different value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      note        <= NOTE_NONE;
      note_change <= 1'b0;
      multi       <= 1'b0;
`ifdef NOTE_SUSTAIN_EN
      sus_cnt     <= '0;
`endif
    end else begin
      multi       <= ($countones(stable) > 1);
      note_change <= 1'b0;
      case (state)
        IDLE: begin
          if (enc != NOTE_NONE) begin
            note        <= enc;
            note_change <= 1'b1;
            state       <= PLAY;
          end
        end
        PLAY: begin
          if (enc == NOTE_NONE) begin
`ifdef NOTE_SUSTAIN_EN
            sus_cnt <= '0;
            state   <= SUSTAIN;
`else
            note        <= NOTE_NONE;
            note_change <= 1'b1;
            state       <= IDLE;
`endif
          end else if (enc != note) begin
            note        <= enc;
            note_change <= 1'b1;
          end
        end
`ifdef NOTE_SUSTAIN_EN
        SUSTAIN: begin
          if (enc != NOTE_NONE) begin
            note        <= enc;
            note_change <= (enc != note);
            sus_cnt     <= '0;
            state       <= PLAY;
          end else if (sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1)) begin
            note        <= NOTE_NONE;
            note_change <= 1'b1;
            state       <= IDLE;
          end else begin
            sus_cnt <= sus_cnt + SUS_W'(1);
          end
        end
`endif
        default: begin
          note        <= NOTE_NONE;
          note_change <= (note != NOTE_NONE);
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_key_encoder.sv
// Table-driven bench for note_key_encoder with a pulse scoreboard; runs with
// DEBOUNCE_CYCLES=4 and SUSTAIN_CYCLES=10, sustain checks under NOTE_SUSTAIN_EN.
module tb_note_key_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic [3:0] note;
  logic       note_change;
  logic       multi;

  int total_checks = 0;
  int pass_checks  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] popped;

  typedef struct {
    logic [7:0] keys;
    logic [3:0] exp_note;
    logic       exp_multi;
    logic       exp_pulse;
  } vec_t;

  vec_t vecs[10];

  note_key_encoder #(
    .DEBOUNCE_CYCLES (4),
    .DB_W            (3),
    .SUSTAIN_CYCLES  (10),
    .SUS_W           (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .note        (note),
    .note_change (note_change),
    .multi       (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] k, input logic [3:0] exp_note, input logic pulse);
    if (pulse) exp_q.push_back(exp_note);
    keys = k;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_note, input logic exp_multi);
    check({name, "_note"}, {4'd0, note}, {4'd0, exp_note});
    check({name, "_multi"}, {7'd0, multi}, {7'd0, exp_multi});
    check({name, "_pending"}, 8'(exp_q.size()), 8'd0);
  endtask

  // Scoreboard: every note_change pulse must match the next expected note.
  always @(negedge clk) begin
    if (rst_n && note_change) begin
      if (exp_q.size() == 0) begin
        total_checks++;
        $display("[TB] FAIL unexpected_pulse: got pulse with note %0d, expected no pulse", note);
      end else begin
        popped = exp_q.pop_front();
        check("pulse_note", {4'd0, note}, {4'd0, popped});
      end
    end
  end

  initial begin
    vecs[0] = '{8'h81, 4'd0, 1'b1, 1'b1};
    vecs[1] = '{8'h80, 4'd7, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 4'd8, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 4'd0, 1'b0, 1'b1};
    vecs[4] = '{8'h03, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{8'h0C, 4'd2, 1'b1, 1'b1};
    vecs[6] = '{8'h60, 4'd5, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 4'd0, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 4'd8, 1'b0, 1'b1};
    vecs[9] = '{8'h10, 4'd4, 1'b0, 1'b1};

    rst_n = 1'b0;
    keys  = 8'h00;
    step(3);
    checkOutput("reset", 4'd8, 1'b0);
    check("reset_change", {7'd0, note_change}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(1);
      check("idle_note", {4'd0, note}, 8'd8);
      check("idle_change", {7'd0, note_change}, 8'd0);
      check("idle_multi", {7'd0, multi}, 8'd0);
    end

    // Bouncing key never survives long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h01 : 8'h00, 4'd0, 1'b0);
      step(2);
      check("bounce_note", {4'd0, note}, 8'd8);
    end
    applyStimulus(8'h00, 4'd0, 1'b0);
    step(15);
    checkOutput("bounce_settle", 4'd8, 1'b0);

    // Latency: key edge to note is 3+4+1 = 8 cycles.
    applyStimulus(8'h08, 4'd3, 1'b1);
    step(7);
    check("lat_before_note", {4'd0, note}, 8'd8);
    step(1);
    check("lat_note", {4'd0, note}, 8'd3);
    check("lat_pulse", {7'd0, note_change}, 8'd1);
    check("lat_multi", {7'd0, multi}, 8'd0);
    step(1);
    check("lat_pulse_end", {7'd0, note_change}, 8'd0);
    step(20);
    checkOutput("lat_hold", 4'd3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].keys, vecs[i].exp_note, vecs[i].exp_pulse);
      step(30);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_note, vecs[i].exp_multi);
    end

    // Release timing from note 4.
    applyStimulus(8'h00, 4'd8, 1'b1);
`ifdef NOTE_SUSTAIN_EN
    step(17);
    check("sus_hold_note", {4'd0, note}, 8'd4);
    step(1);
    check("sus_end_note", {4'd0, note}, 8'd8);
    check("sus_end_pulse", {7'd0, note_change}, 8'd1);
`else
    step(7);
    check("rel_before_note", {4'd0, note}, 8'd4);
    step(1);
    check("rel_note", {4'd0, note}, 8'd8);
    check("rel_pulse", {7'd0, note_change}, 8'd1);
`endif
    step(10);
    checkOutput("rel_done", 4'd8, 1'b0);

`ifdef NOTE_SUSTAIN_EN
    applyStimulus(8'h10, 4'd4, 1'b1);
    step(30);
    checkOutput("sus_press", 4'd4, 1'b0);
    // Same key re-pressed during the hold: no pulse, back to PLAY.
    applyStimulus(8'h00, 4'd0, 1'b0);
    step(8);
    applyStimulus(8'h10, 4'd0, 1'b0);
    step(30);
    checkOutput("sus_repress", 4'd4, 1'b0);
    // Different key lands exactly on the timeout cycle and must win.
    applyStimulus(8'h00, 4'd0, 1'b0);
    step(10);
    applyStimulus(8'h04, 4'd2, 1'b1);
    step(7);
    check("sus_new_before", {4'd0, note}, 8'd4);
    step(1);
    check("sus_new_note", {4'd0, note}, 8'd2);
    step(20);
    checkOutput("sus_new_hold", 4'd2, 1'b0);
`endif

    // Asynchronous reset mid-cycle with keys held, then re-acceptance.
    applyStimulus(8'h0C, 4'd2, (note != 4'd2));
    step(30);
    checkOutput("pre_reset", 4'd2, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_note", {4'd0, note}, 8'd8);
    check("async_multi", {7'd0, multi}, 8'd0);
    check("async_change", {7'd0, note_change}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd2);
    step(7);
    check("rearm_before", {4'd0, note}, 8'd8);
    step(1);
    check("rearm_note", {4'd0, note}, 8'd2);
    check("rearm_multi", {7'd0, multi}, 8'd1);
    step(5);
    checkOutput("rearm_hold", 4'd2, 1'b1);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
